// File: rtl/popcount_pkg.sv
// Shared constants and FSM state type for the popcount frame accumulator.
package popcount_pkg;

    // Per-word popcount width: covers 0..64.
    localparam int unsigned CNT_W     = 7;
    // Frame-length field width.
    localparam int unsigned LEN_W     = 16;
    // Frame-sum width: 64 * (2^16 - 1) fits without wrap.
    localparam int unsigned SUM_W     = 22;
    // Bits per upstream word; largest legal popcount.
    localparam int unsigned WORD_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/popcount_accum.sv
// Frame popcount accumulator: sums per-word popcounts over a frame of
// frame_len words and presents the total with a valid/ready handshake.
// Optional feature macro: POPCOUNT_ACCUM_MAX_EN adds out_max (largest clamped
// in_count seen in the frame).
module popcount_accum #(
    parameter int unsigned CNT_W = popcount_pkg::CNT_W,
    parameter int unsigned LEN_W = popcount_pkg::LEN_W,
    parameter int unsigned SUM_W = popcount_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_words,
    output logic             busy,
`ifdef POPCOUNT_ACCUM_MAX_EN
    output logic [CNT_W-1:0] out_max,
`endif
    output logic             err_range
);

    import popcount_pkg::*;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             err_q, err_d;
`ifdef POPCOUNT_ACCUM_MAX_EN
    logic [CNT_W-1:0] max_q, max_d;
`endif

    logic             accept;
    logic             over_range;
    logic [CNT_W-1:0] clamped;
    logic [LEN_W-1:0] words_inc;

    // Word acceptance and range clamping of the incoming popcount.
    always_comb begin
        accept     = in_valid && (state_q == ST_ACCUM);
        over_range = (in_count > CNT_W'(WORD_BITS));
        clamped    = over_range ? CNT_W'(WORD_BITS) : in_count;
        words_inc  = words_q + LEN_W'(1);
    end

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        words_d = words_q;
        err_d   = err_q;
`ifdef POPCOUNT_ACCUM_MAX_EN
        max_d   = max_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A word presented alongside start is not consumed.
                if (start) begin
                    len_d   = (frame_len == '0) ? LEN_W'(1) : frame_len;
                    sum_d   = '0;
                    words_d = '0;
`ifdef POPCOUNT_ACCUM_MAX_EN
                    max_d   = '0;
`endif
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    sum_d   = sum_q + SUM_W'(clamped);
                    words_d = words_inc;
                    if (over_range) begin
                        err_d = 1'b1;
                    end
`ifdef POPCOUNT_ACCUM_MAX_EN
                    if (clamped > max_q) begin
                        max_d = clamped;
                    end
`endif
                    if (words_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= LEN_W'(1);
            sum_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
`ifdef POPCOUNT_ACCUM_MAX_EN
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            err_q   <= err_d;
`ifdef POPCOUNT_ACCUM_MAX_EN
            max_q   <= max_d;
`endif
        end
    end

    // Output decode; result registers double as the held output values.
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_sum   = sum_q;
        out_words = words_q;
        err_range = err_q;
`ifdef POPCOUNT_ACCUM_MAX_EN
        out_max   = max_q;
`endif
    end

endmodule

// File: tb/tb_popcount_accum.sv
// Self-checking bench for popcount_accum: a frame-level reference model
// predicts the outputs every cycle; directed scenarios add literal checks.
module tb_popcount_accum;

    localparam int unsigned CNT_W = 7;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned SUM_W = 22;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CNT_W-1:0] in_count = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_sum;
    logic [LEN_W-1:0] out_words;
    logic             busy;
    logic             err_range;
`ifdef POPCOUNT_ACCUM_MAX_EN
    logic [CNT_W-1:0] out_max;
`endif

    popcount_accum #(.CNT_W(CNT_W), .LEN_W(LEN_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_words(out_words), .busy(busy),
`ifdef POPCOUNT_ACCUM_MAX_EN
        .out_max(out_max),
`endif
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "collecting" until it has len words,
    // then "pending" until the consumer takes it.
    bit     m_collecting = 0;
    bit     m_pending    = 0;
    longint m_len = 1, m_sum = 0, m_words = 0, m_max = 0;
    bit     m_err = 0;
    bit     chk_en = 0;

    always @(posedge clk) begin
        longint c;
        if (rst) begin
            m_collecting = 0; m_pending = 0;
            m_sum = 0; m_words = 0; m_max = 0; m_err = 0;
        end else if (m_pending) begin
            if (out_ready) m_pending = 0;
        end else if (m_collecting) begin
            if (in_valid) begin
                c = (in_count > 64) ? 64 : longint'(in_count);
                if (in_count > 64) m_err = 1;
                m_sum += c;
                m_words++;
                if (c > m_max) m_max = c;
                if (m_words == m_len) begin
                    m_collecting = 0;
                    m_pending = 1;
                end
            end
        end else if (start) begin
            m_len = (frame_len == 0) ? 1 : longint'(frame_len);
            m_sum = 0; m_words = 0; m_max = 0;
            m_collecting = 1;
        end
        chk_en = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_collecting);
            chk("out_valid", out_valid, m_pending);
            chk("busy", busy, m_collecting | m_pending);
            chk("err_range", err_range, m_err);
            if (!m_collecting) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_words", out_words, m_words);
`ifdef POPCOUNT_ACCUM_MAX_EN
                chk("out_max", out_max, m_max);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int len);
        start = 1'b1;
        frame_len = LEN_W'(len);
        tick();
        start = 1'b0;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input int c);
        bit rdy;
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_count = CNT_W'(c);
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = in_ready;
            tick();
            if (rdy) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_sum", out_sum, 0);
        rst = 1'b0;
        tick();

        // Frame of 4 with a word offered alongside start (not consumed).
        in_valid = 1'b1;
        in_count = 7'd8;
        begin_frame(4);
        chk("s1_no_early_accept", out_words, 0);
        send(8); in_valid = 1'b1; send(16); in_valid = 1'b1; send(0); in_valid = 1'b1; send(64);
        chk("s1_out_valid", out_valid, 1);
        chk("s1_out_sum", out_sum, 88);
        chk("s1_out_words", out_words, 4);
        chk("s1_model_sum", m_sum, 88);
        take_result();
        chk("s1_idle", busy, 0);
        chk("s1_hold_idle_sum", out_sum, 88);

        // Zero length behaves as one word; result held while consumer stalls.
        begin_frame(0);
        send(5);
        chk("s2_out_sum", out_sum, 5);
        chk("s2_out_words", out_words, 1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            frame_len = 16'd9;
            tick();
            chk("s2_stall_valid", out_valid, 1);
            chk("s2_stall_sum", out_sum, 5);
        end
        start = 1'b0;
        take_result();
        chk("s2_released", out_valid, 0);

        // Out-of-range count clamps to 64 and sets the sticky error.
        begin_frame(2);
        send(100);
        send(65);
        chk("s3_out_sum", out_sum, 128);
        chk("s3_err", err_range, 1);
        take_result();

        // Single word of 64 gives 64; error stays set until reset.
        begin_frame(1);
        send(64);
        chk("s4_out_sum", out_sum, 64);
        chk("s4_err_sticky", err_range, 1);
        take_result();

`ifdef POPCOUNT_ACCUM_MAX_EN
        // Gapped words: maximum tracking.
        begin_frame(3);
        send(3); tick(); tick();
        send(40); tick();
        send(7);
        chk("s5_out_max", out_max, 40);
        chk("s5_out_sum", out_sum, 50);
        take_result();
`endif

        // Reset mid-frame discards the frame.
        begin_frame(4);
        send(1);
        send(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_out_valid", out_valid, 0);
        chk("s6_busy", busy, 0);
        chk("s6_out_sum", out_sum, 0);
        chk("s6_out_words", out_words, 0);
        chk("s6_err", err_range, 0);
        tick();
        tick();
        chk("s6_still_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
